// File: rtl/reg_file_mp_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg: shared types and helpers for the multi-read-port register file.
//   state_t    : INIT (clear sweep running) / READY (array usable)
//   addr_width : register address width for a given register count
//   REG_ZERO   : hard-wired zero register index
// ---------------------------------------------------------------------------
package rf_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int REG_ZERO = 0;

    function automatic int addr_width(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// ---------------------------------------------------------------------------
// reg_file_mp_if: decode/writeback-side bus of the register file.
//   clr        : request a full clear sweep (taken only in READY)
//   ready      : array initialised and usable
//   we/wa/wd   : writeback write port
//   ra/rd      : NRD packed read ports, port i at [i*AW +: AW] / [i*XLEN +: XLEN]
//   rbusy      : per-port "source register has a pending producer"
//   iss_v/iss_a: issue marks destination iss_a busy
//   dbg_state  : current FSM state, for observation only
// master = pipeline side driving the file, slave = the register file itself.
//
// Handshake: there is no valid/ready backpressure on this bus. A write or an
// issue is accepted on any rising edge where its enable is high while ready=1;
// while ready=0 both are silently dropped and reads return zero.
// ---------------------------------------------------------------------------
interface reg_file_mp_if import rf_pkg::*; #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2
);
    localparam int AW = addr_width(NREG);

    logic                  clr;
    logic                  ready;
    logic                  we;
    logic [AW-1:0]         wa;
    logic [XLEN-1:0]       wd;
    logic [NRD*AW-1:0]     ra;
    logic [NRD*XLEN-1:0]   rd;
    logic [NRD-1:0]        rbusy;
    logic                  iss_v;
    logic [AW-1:0]         iss_a;
    state_t                dbg_state;

    modport master (
        output clr, we, wa, wd, ra, iss_v, iss_a,
        input  ready, rd, rbusy, dbg_state
    );

    modport slave (
        input  clr, we, wa, wd, ra, iss_v, iss_a,
        output ready, rd, rbusy, dbg_state
    );

endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard: one busy bit per register for in-flight destinations.
//   i_flush          : synchronous clear of every busy bit (highest priority)
//   i_set_v/i_set_a  : mark a register busy (issue)
//   i_clr_v/i_clr_a  : mark a register idle (writeback)
//   i_ra / o_busy    : NRD combinational lookups
// The caller guarantees register 0 is never set.
// ---------------------------------------------------------------------------
module reg_scoreboard import rf_pkg::*; #(
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int AW   = addr_width(NREG)
) (
    input  logic              clk,
    input  logic              i_flush,
    input  logic              i_set_v,
    input  logic [AW-1:0]     i_set_a,
    input  logic              i_clr_v,
    input  logic [AW-1:0]     i_clr_a,
    input  logic [NRD*AW-1:0] i_ra,
    output logic [NRD-1:0]    o_busy
);

    logic [NREG-1:0] r_busy;

    // Set is applied after clear so that an issue and a writeback to the
    // same register on the same edge leave it busy: the new producer wins.
    always_ff @(posedge clk) begin
        if (i_flush) begin
            r_busy <= '0;
        end else begin
            if (i_clr_v) r_busy[i_clr_a] <= 1'b0;
            if (i_set_v) r_busy[i_set_a] <= 1'b1;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_lookup
        assign o_busy[i] = r_busy[i_ra[i*AW +: AW]];
    end

endmodule

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp: parametrised register file with NRD combinational read ports,
// one write port, a hardware clear sweep and a busy scoreboard.
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-low reset; restarts the clear sweep
//   bus : reg_file_mp_if slave (read/write/issue/clear/ready, see interface)
// Parameters: XLEN data width, NREG register count (power of two, >= 4),
// NRD read ports (1..4), BYPASS=1 forwards same-cycle write data to reads.
// ---------------------------------------------------------------------------
module reg_file_mp import rf_pkg::*; #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic           clk,
    input  logic           rst,
    reg_file_mp_if.slave   bus
);

    localparam int AW = addr_width(NREG);

    state_t          r_state;
    logic            r_ready;
    logic [AW-1:0]   r_ptr;
    logic [XLEN-1:0] r_mem [NREG];

    logic            w_active;
    logic            w_wr;
    logic            w_iss;
    logic            w_flush;
    logic [NRD-1:0]  w_sb_busy;

    // Reads, writes and issues only take effect in READY; holding rst low
    // also blanks the read side so nothing stale is visible during reset.
    assign w_active = rst && (r_state == READY);
    assign w_wr     = w_active && bus.we && (bus.wa != AW'(REG_ZERO));
    assign w_iss    = w_active && bus.iss_v && (bus.iss_a != AW'(REG_ZERO));
    assign w_flush  = !rst || (w_active && bus.clr);

    // Sweep FSM: INIT zeroes one register per edge, READY waits for clr.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= INIT;
            r_ptr   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == AW'(NREG - 1)) begin
                        r_state <= READY;
                        r_ready <= 1'b1;
                    end
                end
                READY: begin
                    if (bus.clr) begin
                        r_state <= INIT;
                        r_ptr   <= '0;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= INIT;
                    r_ptr   <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset of its own: the sweep is what initialises it.
    always_ff @(posedge clk) begin
        if (rst && (r_state == INIT)) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr) begin
            r_mem[bus.wa] <= bus.wd;
        end
    end

    reg_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .AW   (AW)
    ) u_scoreboard (
        .clk     (clk),
        .i_flush (w_flush),
        .i_set_v (w_iss),
        .i_set_a (bus.iss_a),
        .i_clr_v (w_wr),
        .i_clr_a (bus.wa),
        .i_ra    (bus.ra),
        .o_busy  (w_sb_busy)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_hit;

        assign w_ra  = bus.ra[i*AW +: AW];
        // w_wr already excludes register 0 and non-READY cycles.
        assign w_hit = (BYPASS != 0) && w_wr && (bus.wa == w_ra);

        assign bus.rd[i*XLEN +: XLEN] =
            (!w_active || (w_ra == AW'(REG_ZERO))) ? '0 :
            w_hit                                  ? bus.wd :
                                                     r_mem[w_ra];

        // A write landing this cycle retires the producer, so hide busy.
        assign bus.rbusy[i] = w_active && w_sb_busy[i] && !w_hit;
    end

    assign bus.ready     = r_ready;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: dut index 0 has BYPASS=1, index 1 has BYPASS=0.
// Both see identical stimulus; a behavioural model supplies expectations.
module tb_reg_file_mp;
  import rf_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- stimulus signals ----------------
  logic              clr, we, iss_v;
  logic [AW-1:0]     wa, iss_a;
  logic [XLEN-1:0]   wd;
  logic [NRD*AW-1:0] ra;

  reg_file_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus_b ();
  reg_file_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus_n ();

  assign bus_b.clr = clr;   assign bus_n.clr = clr;
  assign bus_b.we = we;     assign bus_n.we = we;
  assign bus_b.wa = wa;     assign bus_n.wa = wa;
  assign bus_b.wd = wd;     assign bus_n.wd = wd;
  assign bus_b.ra = ra;     assign bus_n.ra = ra;
  assign bus_b.iss_v = iss_v; assign bus_n.iss_v = iss_v;
  assign bus_b.iss_a = iss_a; assign bus_n.iss_a = iss_a;

  logic [NRD*XLEN-1:0] rd_o [2];
  logic [NRD-1:0]      rb_o [2];
  logic                rdy_o [2];
  logic                dbg_o [2];
  assign rd_o[0] = bus_b.rd;    assign rd_o[1] = bus_n.rd;
  assign rb_o[0] = bus_b.rbusy; assign rb_o[1] = bus_n.rbusy;
  assign rdy_o[0] = bus_b.ready; assign rdy_o[1] = bus_n.ready;
  assign dbg_o[0] = bus_b.dbg_state; assign dbg_o[1] = bus_n.dbg_state;

  reg_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );
  reg_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .bus(bus_n)
  );

  // ---------------- scoreboard / model ----------------
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] e;
  int n_vec;
  int n_err;

  logic [XLEN-1:0] mdl [NREG];
  logic            mdl_busy [NREG];
  logic            mdl_ready;
  int              mdl_cnt;

  function automatic logic [XLEN-1:0] model_rd(input int d, input logic [AW-1:0] a);
    if (!rst || !mdl_ready || a == '0) return '0;
    if (d == 0 && we && wa == a) return wd;
    return mdl[a];
  endfunction

  function automatic logic model_rb(input int d, input logic [AW-1:0] a);
    if (!rst || !mdl_ready || a == '0) return 1'b0;
    if (d == 0 && we && wa == a) return 1'b0;
    return mdl_busy[a];
  endfunction

  task automatic model_edge();
    if (!rst) begin
      mdl_ready = 1'b0; mdl_cnt = 0;
      for (int i = 0; i < NREG; i++) mdl_busy[i] = 1'b0;
    end else if (!mdl_ready) begin
      mdl_cnt++;
      if (mdl_cnt == NREG) begin
        mdl_ready = 1'b1;
        for (int i = 0; i < NREG; i++) mdl[i] = '0;
      end
    end else if (clr) begin
      mdl_ready = 1'b0; mdl_cnt = 0;
      for (int i = 0; i < NREG; i++) mdl_busy[i] = 1'b0;
    end else begin
      if (we && wa != '0) begin mdl[wa] = wd; mdl_busy[wa] = 1'b0; end
      if (iss_v && iss_a != '0) mdl_busy[iss_a] = 1'b1;
    end
  endtask

  // Expected order per dut: ready, then (rd, rbusy) per port.
  task automatic push_exp();
    for (int d = 0; d < 2; d++) begin
      exp_q.push_back(XLEN'(mdl_ready));
      for (int p = 0; p < NRD; p++) begin
        exp_q.push_back(model_rd(d, ra[p*AW +: AW]));
        exp_q.push_back(XLEN'(model_rb(d, ra[p*AW +: AW])));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 1'b0; we = 1'b0; iss_v = 1'b0;
    wa = '0; iss_a = '0; wd = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    ra = {AW'(3), AW'(1)};
    repeat (3) step();
    for (int d = 0; d < 2; d++) exp_q.push_back(XLEN'(INIT));
    push_exp();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      e = exp_q.pop_front(); n_vec++;
      if (dbg_o[d] !== e[0]) begin n_err++; $display("FAIL reset_state dut%0d got %b want %b", d, dbg_o[d], e[0]); end
    end
    for (int d = 0; d < 2; d++) begin
      e = exp_q.pop_front(); n_vec++;
      if (rdy_o[d] !== e[0]) begin n_err++; $display("FAIL reset_ready dut%0d got %b want %b", d, rdy_o[d], e[0]); end
      for (int p = 0; p < NRD; p++) begin
        e = exp_q.pop_front(); n_vec++;
        if (rd_o[d][p*XLEN +: XLEN] !== e) begin n_err++; $display("FAIL reset_rd dut%0d p%0d got %h want %h", d, p, rd_o[d][p*XLEN +: XLEN], e); end
        e = exp_q.pop_front(); n_vec++;
        if (rb_o[d][p] !== e[0]) begin n_err++; $display("FAIL reset_rbusy dut%0d p%0d got %b want %b", d, p, rb_o[d][p], e[0]); end
      end
    end
    step();
  endtask

  task automatic test_init();
    rst = 1'b1;
    for (int k = 0; k <= NREG; k++) begin
      ra = {AW'($urandom_range(0, NREG-1)), AW'($urandom_range(0, NREG-1))};
      push_exp();
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        e = exp_q.pop_front(); n_vec++;
        if (rdy_o[d] !== e[0]) begin n_err++; $display("FAIL init_ready k%0d dut%0d got %b want %b", k, d, rdy_o[d], e[0]); end
        for (int p = 0; p < NRD; p++) begin
          e = exp_q.pop_front(); n_vec++;
          if (rd_o[d][p*XLEN +: XLEN] !== e) begin n_err++; $display("FAIL init_rd k%0d dut%0d p%0d got %h want %h", k, d, p, rd_o[d][p*XLEN +: XLEN], e); end
          e = exp_q.pop_front(); n_vec++;
          if (rb_o[d][p] !== e[0]) begin n_err++; $display("FAIL init_rbusy k%0d dut%0d p%0d got %b want %b", k, d, p, rb_o[d][p], e[0]); end
        end
      end
      step();
    end
    // Every register reads zero after the sweep.
    for (int a = 0; a < NREG; a += NRD) begin
      for (int p = 0; p < NRD; p++) ra[p*AW +: AW] = AW'(a + p);
      push_exp();
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        e = exp_q.pop_front(); n_vec++;
        if (rdy_o[d] !== e[0]) begin n_err++; $display("FAIL init_sweep_ready a%0d dut%0d got %b want %b", a, d, rdy_o[d], e[0]); end
        for (int p = 0; p < NRD; p++) begin
          e = exp_q.pop_front(); n_vec++;
          if (rd_o[d][p*XLEN +: XLEN] !== e) begin n_err++; $display("FAIL init_sweep_rd a%0d dut%0d p%0d got %h want %h", a + p, d, p, rd_o[d][p*XLEN +: XLEN], e); end
          e = exp_q.pop_front(); n_vec++;
          if (rb_o[d][p] !== e[0]) begin n_err++; $display("FAIL init_sweep_rbusy a%0d dut%0d got %b want %b", a + p, d, rb_o[d][p], e[0]); end
        end
      end
      step();
    end
  endtask

  // Generic one-cycle check used by the directed scenarios below, each of
  // which sets inputs and then calls this with its own tag.
  task automatic test_cycle(input string tag);
    push_exp();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      e = exp_q.pop_front(); n_vec++;
      if (rdy_o[d] !== e[0]) begin n_err++; $display("FAIL %s_ready dut%0d got %b want %b", tag, d, rdy_o[d], e[0]); end
      for (int p = 0; p < NRD; p++) begin
        e = exp_q.pop_front(); n_vec++;
        if (rd_o[d][p*XLEN +: XLEN] !== e) begin n_err++; $display("FAIL %s_rd dut%0d p%0d got %h want %h", tag, d, p, rd_o[d][p*XLEN +: XLEN], e); end
        e = exp_q.pop_front(); n_vec++;
        if (rb_o[d][p] !== e[0]) begin n_err++; $display("FAIL %s_rbusy dut%0d p%0d got %b want %b", tag, d, p, rb_o[d][p], e[0]); end
      end
    end
    step();
  endtask

  task automatic test_write_read();
    we = 1'b1; wa = AW'(5); wd = 32'hDEADBEEF;
    ra = {AW'(0), AW'(5)};
    test_cycle("wr_same");
    idle_inputs();
    test_cycle("wr_next");
  endtask

  task automatic test_x0();
    we = 1'b1; wa = '0; wd = 32'h12345678;
    iss_v = 1'b1; iss_a = '0;
    ra = '0;
    test_cycle("x0_same");
    idle_inputs();
    test_cycle("x0_next");
  endtask

  task automatic test_scoreboard();
    iss_v = 1'b1; iss_a = AW'(7);
    ra = {AW'(7), AW'(5)};
    test_cycle("sb_issue");
    idle_inputs();
    test_cycle("sb_busy");
    we = 1'b1; wa = AW'(7); wd = 32'h55;
    test_cycle("sb_write");
    idle_inputs();
    test_cycle("sb_after");
    iss_v = 1'b1; iss_a = AW'(9);
    we = 1'b1; wa = AW'(9); wd = 32'hA5A5A5A5;
    ra = {AW'(7), AW'(9)};
    test_cycle("sb_both");
    idle_inputs();
    test_cycle("sb_win");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 24; k++) begin
      we = 1'($urandom_range(0, 1));
      wa = AW'($urandom_range(0, NREG-1));
      wd = $urandom;
      iss_v = ($urandom_range(0, 3) == 0);
      iss_a = AW'($urandom_range(0, NREG-1));
      ra[0 +: AW]  = ($urandom_range(0, 1) == 1) ? wa : AW'($urandom_range(0, NREG-1));
      ra[AW +: AW] = AW'($urandom_range(0, NREG-1));
      test_cycle("b2b");
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    for (int a = 3; a <= 6; a += 1) begin
      if (a == 5) continue;
      iss_v = 1'b1; iss_a = AW'(a);
      ra = {AW'(a), AW'(3)};
      test_cycle("clr_load");
    end
    idle_inputs();
    ra = {AW'(4), AW'(6)};
    test_cycle("clr_busy");
    clr = 1'b1;
    test_cycle("clr_pulse");
    for (int k = 0; k < NREG; k++) begin
      idle_inputs();
      if (k == 0) begin we = 1'b1; wa = AW'(5); wd = 32'hFFFF_FFFF; end
      if (k == 10) clr = 1'b1;
      ra = {AW'(4), AW'(5)};
      test_cycle("clr_sweep");
    end
    idle_inputs();
    for (int a = 0; a < NREG; a += NRD) begin
      for (int p = 0; p < NRD; p++) ra[p*AW +: AW] = AW'(a + p);
      test_cycle("clr_read");
    end
  endtask

  task automatic test_reset_mid_sweep();
    we = 1'b1; wa = AW'(12); wd = 32'h0BADF00D;
    test_cycle("mid_load");
    idle_inputs();
    clr = 1'b1;
    test_cycle("mid_clr");
    clr = 1'b0;
    ra = {AW'(12), AW'(5)};
    for (int k = 0; k < 10; k++) test_cycle("mid_sweep");
    rst = 1'b0;
    test_cycle("mid_rst");
    rst = 1'b1;
    for (int k = 0; k <= NREG; k++) test_cycle("mid_resweep");
    for (int a = 0; a < NREG; a += NRD) begin
      for (int p = 0; p < NRD; p++) ra[p*AW +: AW] = AW'(a + p);
      test_cycle("mid_read");
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

  // ---------------- sequence + report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    mdl_ready = 1'b0;
    mdl_cnt = 0;
    for (int i = 0; i < NREG; i++) begin mdl[i] = '0; mdl_busy[i] = 1'b0; end
    test_reset();
    test_init();
    test_write_read();
    test_x0();
    test_scoreboard();
    test_back_to_back();
    test_clear();
    test_reset_mid_sweep();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain got %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file for the pipelined successor of the single-cycle RV core. Generalises the 2-read/1-write integer register file in width, depth and read-port count; adds a hardware clear sweep with a `ready` flag, optional write-to-read bypass, and a per-register busy scoreboard for in-flight destinations. It sits between decode (read/issue) and writeback (write/retire).

## Interface
- `XLEN`, 32, data width in bits
- `NREG`, 32, register count; power of two, ≥ 4; `AW = $clog2(NREG)`
- `NRD`, 2, number of read ports, 1..4
- `BYPASS`, 1, 1 means same-cycle write data is forwarded to matching reads
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset; synchronous, active-low
- `clr`  in  1  request a full clear sweep; honoured only in READY
- `ready`  out  1  high when the array is initialised and usable
- `we`  in  1  write enable (writeback)
- `wa`  in  AW  write address
- `wd`  in  XLEN  write data
- `ra`  in  NRD*AW  read addresses; port i is `ra[i*AW +: AW]`
- `rd`  out  NRD*XLEN  read data; port i is `rd[i*XLEN +: XLEN]`
- `rbusy`  out  NRD  port i's source register has a pending producer
- `iss_v`  in  1  issue: mark `iss_a` busy
- `iss_a`  in  AW  issue destination address

## Operation
- FSM states: INIT and READY. `rst`=0 at an edge puts the FSM in INIT with `ptr`=0 and clears all busy bits.
- INIT sweep:
  - Each edge with `rst`=1 writes 0 to `reg[ptr]` and increments `ptr`.
  - The edge that writes `ptr`=NREG-1 moves the FSM to READY.
- `clr`=1 in READY: FSM moves to INIT, `ptr`=0, busy cleared. `clr` is ignored in INIT, so the sweep is never restarted.
- In INIT: `we` and `iss_v` are ignored, all `rd`=0, all `rbusy`=0.
- Register 0:
  - Always reads 0.
  - Writes to address 0 are discarded.
  - Issue to address 0 never sets busy.
- Write (READY, `we`=1, `wa`≠0):
  - `reg[wa]` takes `wd` at the edge.
  - `busy[wa]` clears at the edge.
- Read: combinational. `rd[i] = reg[ra[i]]`. If BYPASS=1 and READY and `we` and `wa`==`ra[i]`≠0, then `rd[i]=wd`.
- `rbusy[i] = busy[ra[i]]`. If BYPASS=1, it is masked to 0 when the same-cycle write to `ra[i]` is present.
- Issue (READY, `iss_v`, `iss_a`≠0) sets `busy[iss_a]` at the edge.
- Same edge, same address, issue and write both valid: data is written and busy ends set (the new producer wins).
- A `rst` mid-sweep or mid-operation restarts the sweep from `ptr`=0. No partial state survives.

## Timing
- Reset values while `rst`=0: `ready`=0, `rd`=0, `rbusy`=0.
- Sweep length: `ready` rises after the NREG-th consecutive edge with `rst`=1 and stays high until `clr` or `rst`.
- The same applies after `clr`: `ready` falls the cycle after `clr` is sampled and returns NREG edges later.
- Write-to-read latency:
  - 0 cycles with BYPASS=1.
  - 1 cycle (next cycle after the edge) with BYPASS=0.
- Issue-to-`rbusy` latency: 1 cycle. Write-to-`rbusy`-clear: 0 cycles with BYPASS=1, 1 cycle otherwise.

## Structure
- Package `rf_pkg` holds:
  - the state enum {INIT, READY};
  - an `AW`-from-`NREG` helper function;
  - the zero-register constant `REG_ZERO = 0`.
- Sub-module `reg_scoreboard`: NREG busy bits with set/clear/flush inputs and NRD combinational lookups. The top keeps the array, FSM, sweep pointer and bypass muxes.
- Read ports are generated with a `for` loop over NRD.

## Test plan
- Init: hold `rst`=0 for 3 edges, then release with NREG=32. `ready`=0 and all `rd`=0 for 32 edges, then `ready`=1. Reading any address returns 0.
- Write/read with BYPASS=1: write `wa`=5, `wd`=0xDEADBEEF with `ra[0]`=5 in the same cycle. `rd[0]`=0xDEADBEEF that cycle. With BYPASS=0 it reads the old value 0, then 0xDEADBEEF next cycle.
- x0: write 0x12345678 to address 0 and issue to 0. `rd`=0 and `rbusy`=0 on every port.
- Scoreboard:
  - Issue `iss_a`=7; next cycle `ra[1]`=7 gives `rbusy[1]`=1.
  - Write `wa`=7, `wd`=0x55. With BYPASS=1, `rbusy[1]`=0 the same cycle; the register holds 0x55 afterwards.
  - Issue and write to 9 on one edge: `busy[9]` remains 1.
- Clear: with registers loaded and 3 busy, pulse `clr`. `ready`=0 next cycle and a `we` during the sweep is dropped. After 32 edges all registers read 0 and `rbusy`=0. A second `clr` mid-sweep does not extend the sweep.
- Reset mid-sweep: drop `rst` at sweep edge 10, then release. A full 32-edge sweep precedes `ready`=1.
